// File: rtl/usb3_tx_hp_framer.sv
// usb3_tx_hp_framer: frames one header packet + LCW into HPSTART, 3 header dwords and CRC-16/LCW words
module usb3_tx_hp_framer #(
  parameter int IDLE_GAP = 1
) (
  input  logic        local_clk,
  input  logic        reset,
  input  logic        hp_valid,
  input  logic [95:0] hp_data,
  input  logic [15:0] hp_lcw,
  output logic        hp_ready,
  output logic [31:0] raw_data,
  output logic [3:0]  raw_datak,
  output logic        raw_active,
  input  logic        raw_stall
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] HDR0  = 3'd2;
  localparam logic [2:0] HDR1  = 3'd3;
  localparam logic [2:0] HDR2  = 3'd4;
  localparam logic [2:0] TAIL  = 3'd5;
  localparam logic [2:0] GAP   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [95:0] hdr_q, hdr_d;
  logic [15:0] lcw_q, lcw_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  datak_q, datak_d;
  logic        active_q, active_d;
  logic        rdy_q, rdy_d;
  logic        accept;

  // header bytes go in transmit order, each byte LSB first; result inverted and bit-reversed per byte
  function automatic logic [15:0] crc16(input logic [95:0] h);
    logic [15:0] c;
    logic [15:0] r;
    c = 16'hFFFF;
    for (int i = 0; i < 96; i++)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ h[i]) ? 16'h100B : 16'h0000);
    c = ~c;
    for (int i = 0; i < 8; i++) begin
      r[15-i] = c[8+i];
      r[7-i]  = c[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // a stalled edge holds the scrambler's current word, so nothing advances while raw_stall is high
  assign hp_ready = rdy_q & ~raw_stall;
  assign accept   = hp_valid & hp_ready;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    hdr_d   = hdr_q;
    lcw_d   = lcw_q;
    if (!raw_stall) begin
      case (state_q)
        IDLE: begin
          gap_d = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
          if (accept) begin
            state_d = START;
            hdr_d   = hp_data;
            lcw_d   = hp_lcw;
          end
        end
        START, HDR0, HDR1, HDR2: state_d = state_q + 3'd1;
        TAIL: begin
          state_d = GAP;
          gap_d   = 4'(IDLE_GAP - 1);
        end
        default: begin
          gap_d   = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
          state_d = (gap_q <= 4'd1) ? IDLE : GAP;
        end
      endcase
    end
    data_d   = (state_d == START) ? 32'h5C5C5CF7 :
               (state_d == HDR0)  ? swap(hdr_q[31:0]) :
               (state_d == HDR1)  ? swap(hdr_q[63:32]) :
               (state_d == HDR2)  ? swap(hdr_q[95:64]) :
               (state_d == TAIL)  ? {crc16(hdr_q), lcw_q} : 32'h0;
    datak_d  = (state_d == START) ? 4'hF : 4'h0;
    active_d = (state_d >= START) && (state_d <= TAIL);
    rdy_d    = (state_d == IDLE) && (gap_d == 4'd0);
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gap_q    <= 4'(IDLE_GAP);
      hdr_q    <= '0;
      lcw_q    <= '0;
      data_q   <= '0;
      datak_q  <= '0;
      active_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      hdr_q    <= hdr_d;
      lcw_q    <= lcw_d;
      data_q   <= data_d;
      datak_q  <= datak_d;
      active_q <= active_d;
      rdy_q    <= rdy_d;
    end
  end

  assign raw_data   = data_q;
  assign raw_datak  = datak_q;
  assign raw_active = active_q;
endmodule

// File: tb/tb_usb3_tx_hp_framer.sv
// tb_usb3_tx_hp_framer: scoreboard bench for the header-packet framer (IDLE_GAP=3)
module tb_usb3_tx_hp_framer;
  logic        clk = 1'b0;
  logic        reset, hp_valid, hp_ready, raw_active, raw_stall;
  logic [95:0] hp_data;
  logic [15:0] hp_lcw;
  logic [31:0] raw_data;
  logic [3:0]  raw_datak;

  int n_chk = 0, n_err = 0, n_acc = 0, n_gap = 0, idle_n = 0, pos = 0;
  logic        prev_stall = 1'b0, exp_start = 1'b0, tail_seen = 1'b0, gap_chk = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_k;
  logic [35:0] sb[$];
  logic [35:0] e;

  localparam logic [95:0] H3 = 96'h0C0B0A09_08070605_04030201;

  usb3_tx_hp_framer #(.IDLE_GAP(3)) dut (
    .local_clk(clk), .reset(reset), .hp_valid(hp_valid), .hp_data(hp_data),
    .hp_lcw(hp_lcw), .hp_ready(hp_ready), .raw_data(raw_data), .raw_datak(raw_datak),
    .raw_active(raw_active), .raw_stall(raw_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_crc(input logic [95:0] h);
    logic [15:0] c, r;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int k = 0; k < 12; k++) begin
      b = h[8*k +: 8];
      for (int j = 0; j < 8; j++) begin
        c = (c[15] ^ b[0]) ? ((c << 1) ^ 16'h100B) : (c << 1);
        b = b >> 1;
      end
    end
    c = c ^ 16'hFFFF;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r[8+j] = c[15-j];
      r[j]   = c[7-j];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_dw(input logic [95:0] h, input int n);
    return {h[8*(4*n) +: 8], h[8*(4*n+1) +: 8], h[8*(4*n+2) +: 8], h[8*(4*n+3) +: 8]};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      prev_stall = 1'b0;
      exp_start  = 1'b0;
      tail_seen  = 1'b0;
      pos        = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", raw_data, prev_data);
        chk("hold_k", {28'b0, raw_datak}, {28'b0, prev_k});
      end
      if (raw_stall) chk("rdy_stall", {31'b0, hp_ready}, 32'd0);
      if (exp_start) begin
        chk("latency", raw_data, 32'h5C5C5CF7);
        exp_start = 1'b0;
      end
      if (!raw_stall) begin
        if (raw_active) begin
          if (sb.size() == 0) chk("extra_word", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("data", raw_data, e[35:4]);
            chk("datak", {28'b0, raw_datak}, {28'b0, e[3:0]});
            if (pos == 0 && gap_chk && tail_seen) begin
              chk("gap", 32'(idle_n), 32'd3);
              n_gap++;
            end
            if (pos == 4) begin
              tail_seen = 1'b1;
              idle_n    = 0;
              pos       = 0;
            end else pos++;
          end
        end else begin
          chk("idle_data", raw_data, 32'd0);
          chk("idle_k", {28'b0, raw_datak}, 32'd0);
          idle_n++;
        end
      end
      if (hp_valid && hp_ready) begin
        sb.push_back({32'h5C5C5CF7, 4'hF});
        for (int n = 0; n < 3; n++) sb.push_back({model_dw(hp_data, n), 4'h0});
        sb.push_back({model_crc(hp_data), hp_lcw, 4'h0});
        exp_start = 1'b1;
        n_acc++;
      end
    end
    prev_stall = raw_stall;
    prev_data  = raw_data;
    prev_k     = raw_datak;
  end

  task automatic send(input logic [95:0] h, input logic [15:0] l);
    int n;
    hp_valid = 1'b1;
    hp_data  = h;
    hp_lcw   = l;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (hp_ready) break;
    end
    if (n == 100) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_word(input logic [31:0] w);
    int n;
    for (n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (raw_data == w) break;
    end
    if (n == 50) chk("word_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !raw_active) break;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n0;
    reset = 1'b1; hp_valid = 1'b0; hp_data = '0; hp_lcw = '0; raw_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", raw_data, 32'd0);
    chk("rst_k", {28'b0, raw_datak}, 32'd0);
    chk("rst_active", {31'b0, raw_active}, 32'd0);
    chk("rst_ready", {31'b0, hp_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_low", {31'b0, hp_ready}, 32'd0);
    repeat (10) @(negedge clk);
    chk("ready_high", {31'b0, hp_ready}, 32'd1);
    @(posedge clk); #1;

    send(96'h0, 16'h0000);
    hp_valid = 1'b0;
    drain();

    send(H3, 16'hA5C3);
    hp_valid = 1'b0;
    drain();

    send(H3, 16'hA5C3);
    hp_valid = 1'b0;
    wait_word(32'h05060708);
    raw_stall = 1'b1;
    repeat (2) @(posedge clk);
    #1 raw_stall = 1'b0;
    drain();

    n0 = n_acc;
    hp_valid = 1'b1; hp_data = 96'h1; hp_lcw = 16'h1234;
    raw_stall = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("no_accept_stalled", 32'(n_acc - n0), 32'd0);
    raw_stall = 1'b0;
    send(96'hDEADBEEF_CAFEF00D_12345678, 16'h8001);
    hp_valid = 1'b0;
    drain();

    n0 = n_acc;
    send(96'hFFFFFFFF_00000000_FFFFFFFF, 16'h00FF);
    @(posedge clk); #1 gap_chk = 1'b1;
    send(96'h80000000_00000001_55AA55AA, 16'hFF00);
    hp_valid = 1'b0;
    drain();
    gap_chk = 1'b0;
    chk("accepts_b2b", 32'(n_acc - n0), 32'd2);
    chk("gap_seen", 32'(n_gap), 32'd1);

    send(H3, 16'h7E81);
    hp_valid = 1'b0;
    wait_word(32'h05060708);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_data", raw_data, 32'd0);
    chk("abort_active", {31'b0, raw_active}, 32'd0);
    chk("abort_ready", {31'b0, hp_ready}, 32'd0);
    @(posedge clk); #1;
    send(96'h0C0B0A09_08070605_04030201, 16'h3C3C);
    hp_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
